button_debounce_array: RTL and testbench
========================================

BUTTON_DEBOUNCE_ARRAY -- requirements
Module: button_debounce_array

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of independent button channels, minimum 1.
REQ-002 SHALL have parameter DEB_CYCLES, default 1048576: stable-sample count for press/release qualification, minimum 2.
REQ-003 SHALL have parameter REP_DELAY, default 12500000: cycles from first pulse to first auto-repeat pulse, minimum 2.
REQ-004 SHALL have parameter REP_PERIOD, default 2500000: cycles between later auto-repeat pulses, minimum 2.
REQ-005 SHALL have port clock_25  input  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port async_button  input  N_CH  raw, unsynchronised button levels, active-high.
REQ-008 SHALL have port en_rise  input  N_CH  per channel: 1 = pulse mode, 0 = level mode.
REQ-009 SHALL have port en_repeat  input  N_CH  per channel auto-repeat enable; honoured only when en_rise is 1.
REQ-010 SHALL have port sync_button  output  N_CH  debounced output, registered, format per mode.
REQ-011 SHALL have port pressed  output  N_CH  debounced level, registered, independent of mode.
REQ-012 SHALL have port any_event  output  1  registered OR of all pulse-mode pulses issued this cycle.

Function
REQ-013 Each async_button bit SHALL pass a 2-flop synchronizer; s[i] = second flop output.
REQ-014 Each channel SHALL run its own FSM {IDLE, PRESS, HELD, RELEASE} with its own debounce counter sized $clog2(DEB_CYCLES).
REQ-015 IDLE: s=1 -> PRESS, counter cleared; else stay.
REQ-016 PRESS: s=0 -> IDLE, no output; s=1 and counter==DEB_CYCLES-1 -> HELD; otherwise counter increments.
REQ-017 HELD: s=0 -> RELEASE, counter cleared; else stay.
REQ-018 RELEASE: s=1 -> HELD, no new press pulse; s=1 glitch SHALL NOT restart repeat timing; s=0 and counter==DEB_CYCLES-1 -> IDLE; otherwise counter increments.
REQ-019 pressed[i] SHALL be 1 exactly while the channel is in HELD or RELEASE, updated on the edge of the state change.
REQ-020 Level mode: sync_button[i] SHALL equal pressed[i].
REQ-021 Pulse mode: sync_button[i] SHALL be high for exactly one cycle, starting on the PRESS->HELD edge.
REQ-022 Latency: input rising before edge 1, held stable -> PRESS->HELD at edge DEB_CYCLES+3.
REQ-023 Repeat counter, sized $clog2(max(REP_DELAY,REP_PERIOD)+1), SHALL clear on HELD entry from PRESS, increment in HELD, hold in RELEASE, and never wrap.
REQ-024 With en_rise[i]=en_repeat[i]=1, repeat pulses SHALL occur REP_DELAY cycles after the press pulse, then every REP_PERIOD cycles while HELD.
REQ-025 No repeat pulses SHALL be issued in RELEASE or IDLE; leaving to IDLE discards repeat timing.
REQ-026 Mode inputs SHALL be sampled live; a change affects output from the next edge and never alters FSM state.
REQ-027 Channels SHALL be fully independent; simultaneous events on several channels SHALL each produce their own output.
REQ-028 any_event SHALL assert in the same cycle as any pulse-mode press or repeat pulse; it is 1 cycle wide per cycle containing a pulse.

Reset
REQ-029 reset low SHALL asynchronously force all FSMs to IDLE; clear all counters and synchronizer flops; drive sync_button, pressed, and any_event to 0.
REQ-030 reset asserted mid-operation SHALL abort any in-progress debounce or repeat; no pulse is emitted on reset release.
REQ-031 After reset release, an input already high SHALL be qualified as a fresh press per REQ-022.

Verification (DEB_CYCLES=8, REP_DELAY=20, REP_PERIOD=5, N_CH=4)
REQ-032 ch0, en_rise=1, input high from before edge 1 -> sync_button[0] and any_event high only after edge 11 until edge 12.
REQ-033 ch1, en_rise=0, high 30 cycles then low -> sync_button[1]=pressed[1] rises at edge 11 and falls 8+3 edges after the input falls.
REQ-034 ch2 bounce: 1 for 5 cycles, 0 for 2 cycles, then 1 steady -> exactly one pulse, no pulse from the first burst.
REQ-035 ch0, en_repeat=1, held 50 cycles -> pulses at edges 11, 31, 36, 41, 46, 51; none after release.
REQ-036 ch0 and ch3 pressed on the same cycle -> both pulse on the same edge; any_event high for one cycle.
REQ-037 reset pulsed low at edge 7 of a press -> all outputs 0 immediately; the press is requalified with the pulse 11 edges after release.

Source files
------------

// File: rtl/button_debounce_array.sv
// button_debounce_array
//   Debounces N_CH independent push buttons. Each channel synchronises its raw
//   input, qualifies presses and releases with a stable-sample counter and then
//   presents either a debounced level or a one-cycle pulse. In pulse mode the
//   channel can also auto-repeat while the button stays held.
//
// Ports
//   clock_25     : sole clock, all state moves on its rising edge
//   reset        : asynchronous, active-low reset
//   async_button : raw, unsynchronised button levels (active-high), one per channel
//   en_rise      : per channel, 1 = pulse mode, 0 = level mode
//   en_repeat    : per channel auto-repeat enable, only honoured in pulse mode
//   sync_button  : registered debounced output (level or pulse, per mode)
//   pressed      : registered debounced level, independent of mode
//   any_event    : registered OR of every pulse-mode pulse issued this cycle

`timescale 1ns/1ps

module button_debounce_array #(
  parameter int N_CH       = 4,
  parameter int DEB_CYCLES = 1048576,
  parameter int REP_DELAY  = 12500000,
  parameter int REP_PERIOD = 2500000
) (
  input  logic            clock_25,
  input  logic            reset,
  input  logic [N_CH-1:0] async_button,
  input  logic [N_CH-1:0] en_rise,
  input  logic [N_CH-1:0] en_repeat,
  output logic [N_CH-1:0] sync_button,
  output logic [N_CH-1:0] pressed,
  output logic            any_event
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PRESS   = 2'd1;
  localparam logic [1:0] ST_HELD    = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  localparam int REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
  localparam int DEB_W   = $clog2(DEB_CYCLES);
  localparam int REP_W   = $clog2(REP_MAX + 1);

  localparam logic [DEB_W-1:0] DEB_LAST    = DEB_W'(DEB_CYCLES - 1);
  localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REP_DELAY - 1);
  localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REP_PERIOD - 1);

  // Per-channel pulse requests, gathered for any_event.
  logic [N_CH-1:0] pulse;

  genvar i;
  generate
    for (i = 0; i < N_CH; i++) begin : g_ch
      logic [1:0]       sync_ff;
      logic             s;
      logic [1:0]       state;
      logic [1:0]       next_state;
      logic [DEB_W-1:0] deb_cnt;
      logic [REP_W-1:0] rep_cnt;
      logic             rep_phase;
      logic [REP_W-1:0] rep_target;
      logic             press_fire;
      logic             rep_tick;
      logic             next_pressed;
      logic             pressed_q;
      logic             sync_q;

      assign s = sync_ff[1];

      // The repeat counter first runs out the initial delay, then restarts
      // for every period; rep_phase records which of the two it is timing.
      // A repeat tick only counts while the button is still held this edge.
      always_comb begin
        next_state   = state;
        press_fire   = 1'b0;
        rep_target   = rep_phase ? PERIOD_LAST : DELAY_LAST;
        rep_tick     = (state == ST_HELD) && s && (rep_cnt == rep_target);
        case (state)
          ST_IDLE: begin
            if (s) next_state = ST_PRESS;
          end
          ST_PRESS: begin
            if (!s) begin
              next_state = ST_IDLE;
            end else if (deb_cnt == DEB_LAST) begin
              next_state = ST_HELD;
              press_fire = 1'b1;
            end
          end
          ST_HELD: begin
            if (!s) next_state = ST_RELEASE;
          end
          default: begin
            if (s) begin
              next_state = ST_HELD;
            end else if (deb_cnt == DEB_LAST) begin
              next_state = ST_IDLE;
            end
          end
        endcase
        next_pressed = (next_state == ST_HELD) || (next_state == ST_RELEASE);
        pulse[i]     = en_rise[i] && (press_fire || (en_repeat[i] && rep_tick));
      end

      // Synchroniser, FSM and both counters. The repeat counter is frozen in
      // RELEASE so a release glitch back to HELD resumes the old timing, and
      // it is only restarted by a fresh press or by a repeat boundary.
      always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
          sync_ff   <= 2'b00;
          state     <= ST_IDLE;
          deb_cnt   <= '0;
          rep_cnt   <= '0;
          rep_phase <= 1'b0;
          pressed_q <= 1'b0;
          sync_q    <= 1'b0;
        end else begin
          sync_ff   <= {sync_ff[0], async_button[i]};
          state     <= next_state;
          pressed_q <= next_pressed;
          sync_q    <= en_rise[i] ? pulse[i] : next_pressed;
          case (state)
            ST_IDLE: begin
              deb_cnt   <= '0;
              rep_cnt   <= '0;
              rep_phase <= 1'b0;
            end
            ST_PRESS: begin
              if (s) begin
                if (deb_cnt == DEB_LAST) begin
                  rep_cnt   <= '0;
                  rep_phase <= 1'b0;
                end else begin
                  deb_cnt <= deb_cnt + 1'b1;
                end
              end
            end
            ST_HELD: begin
              if (!s) begin
                deb_cnt <= '0;
              end else if (rep_tick) begin
                rep_cnt   <= '0;
                rep_phase <= 1'b1;
              end else begin
                rep_cnt <= rep_cnt + 1'b1;
              end
            end
            default: begin
              if (!s && (deb_cnt != DEB_LAST)) begin
                deb_cnt <= deb_cnt + 1'b1;
              end
            end
          endcase
        end
      end

      assign pressed[i]     = pressed_q;
      assign sync_button[i] = sync_q;
    end
  endgenerate

  // One flag per cycle that holds at least one pulse-mode pulse on any channel.
  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      any_event <= 1'b0;
    end else begin
      any_event <= |pulse;
    end
  end

endmodule

// File: tb/tb_button_debounce_array.sv
// tb_button_debounce_array
//   Directed bench for button_debounce_array (N_CH=4, DEB_CYCLES=8,
//   REP_DELAY=20, REP_PERIOD=5). A run-length model of every channel predicts
//   the outputs and is compared on each falling edge; directed sequences add
//   hand-computed edge numbers for presses, releases, repeats and reset.

`timescale 1ns/1ps

module tb_button_debounce_array;

  localparam int N_CH = 4;
  localparam int DEB  = 8;
  localparam int RD   = 20;
  localparam int RP   = 5;

  logic            clock_25 = 1'b0;
  logic            reset    = 1'b0;
  logic [N_CH-1:0] async_button = '0;
  logic [N_CH-1:0] en_rise      = '0;
  logic [N_CH-1:0] en_repeat    = '0;
  logic [N_CH-1:0] sync_button;
  logic [N_CH-1:0] pressed;
  logic            any_event;

  int checks = 0;
  int passes = 0;
  int edge_no = 0;
  int base = 0;
  logic cmp_en = 1'b0;

  button_debounce_array #(
    .N_CH(N_CH), .DEB_CYCLES(DEB), .REP_DELAY(RD), .REP_PERIOD(RP)
  ) dut (
    .clock_25(clock_25),
    .reset(reset),
    .async_button(async_button),
    .en_rise(en_rise),
    .en_repeat(en_repeat),
    .sync_button(sync_button),
    .pressed(pressed),
    .any_event(any_event)
  );

  always #20 clock_25 = ~clock_25;

  always @(posedge clock_25) edge_no = edge_no + 1;

  // Behavioural model: s is the input seen two edges late; a press is
  // qualified once s has read 1 for DEB+1 consecutive edges, a release once
  // it has read 0 for DEB+1 edges. Repeats fall at held ages RD, RD+RP, ...
  logic [N_CH-1:0] m_p0, m_p1, m_pressed, m_sync;
  logic            m_any;
  int one_run [N_CH];
  int zero_run[N_CH];
  int age     [N_CH];

  always @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      m_p0 = '0; m_p1 = '0; m_pressed = '0; m_sync = '0; m_any = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        one_run[i] = 0; zero_run[i] = 0; age[i] = 0;
      end
    end else begin
      m_any = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        logic s, was_held, press_p, rep_p, pl;
        s        = m_p1[i];
        m_p1[i]  = m_p0[i];
        m_p0[i]  = async_button[i];
        was_held = m_pressed[i] && (zero_run[i] == 0);
        if (s) begin
          one_run[i] = one_run[i] + 1; zero_run[i] = 0;
        end else begin
          zero_run[i] = zero_run[i] + 1; one_run[i] = 0;
        end
        press_p = 1'b0;
        rep_p   = 1'b0;
        if (!m_pressed[i]) begin
          if (one_run[i] >= DEB + 1) begin
            m_pressed[i] = 1'b1; age[i] = 0; press_p = 1'b1;
          end
        end else if (zero_run[i] >= DEB + 1) begin
          m_pressed[i] = 1'b0;
        end else if (was_held && s) begin
          age[i] = age[i] + 1;
          if (age[i] >= RD && ((age[i] - RD) % RP) == 0) rep_p = 1'b1;
        end
        pl = en_rise[i] && (press_p || (en_repeat[i] && rep_p));
        m_sync[i] = en_rise[i] ? pl : m_pressed[i];
        m_any = m_any | pl;
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
  endtask

  task automatic apply_stimulus(input int ch, input logic value);
    async_button[ch] = value;
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clock_25) begin
    if (cmp_en) begin
      check_output("model_sync_button", 32'(sync_button), 32'(m_sync));
      check_output("model_pressed",     32'(pressed),     32'(m_pressed));
      check_output("model_any_event",   32'(any_event),   32'(m_any));
    end
  end

  // Next rising edge becomes relative edge 1.
  task automatic mark_edge0();
    base = edge_no;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clock_25);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Reset state
    idle_cycles(2);
    cmp_en = 1'b1;
    check_output("reset_sync_button", 32'(sync_button), 32'd0);
    check_output("reset_pressed",     32'(pressed),     32'd0);
    check_output("reset_any_event",   32'(any_event),   32'd0);
    #5 reset = 1'b1;
    idle_cycles(3);

    // Single pulse-mode press on ch0: pulse after edge 11 only
    @(negedge clock_25);
    en_rise = 4'b0001; en_repeat = 4'b0000;
    mark_edge0();
    apply_stimulus(0, 1'b1);
    for (int k = 1; k <= 25; k++) begin
      @(negedge clock_25);
      check_output("t1_sync0", 32'(sync_button[0]), 32'(k == 11));
      check_output("t1_any",   32'(any_event),      32'(k == 11));
      check_output("t1_pressed0", 32'(pressed[0]),  32'(k >= 11));
    end
    apply_stimulus(0, 1'b0);
    idle_cycles(15);
    check_output("t1_released0", 32'(pressed[0]), 32'd0);

    // Level mode on ch1: high 30 cycles, rises at edge 11, falls at edge 41
    en_rise = 4'b0000;
    mark_edge0();
    apply_stimulus(1, 1'b1);
    for (int k = 1; k <= 50; k++) begin
      @(negedge clock_25);
      check_output("t2_sync1",    32'(sync_button[1]), 32'(k >= 11 && k < 41));
      check_output("t2_pressed1", 32'(pressed[1]),     32'(k >= 11 && k < 41));
      if (k == 30) apply_stimulus(1, 1'b0);
    end
    idle_cycles(5);

    // Bounce on ch2: 5 high, 2 low, then steady high -> single pulse at edge 18
    en_rise = 4'b0100;
    begin
      int pulses;
      pulses = 0;
      mark_edge0();
      apply_stimulus(2, 1'b1);
      for (int k = 1; k <= 30; k++) begin
        @(negedge clock_25);
        if (sync_button[2]) pulses++;
        check_output("t3_sync2", 32'(sync_button[2]), 32'(k == 18));
        if (k == 5) apply_stimulus(2, 1'b0);
        if (k == 7) apply_stimulus(2, 1'b1);
      end
      check_output("t3_pulse_count", 32'(pulses), 32'd1);
    end
    apply_stimulus(2, 1'b0);
    idle_cycles(15);

    // Auto-repeat on ch0, held 50 cycles: pulses at 11,31,36,41,46,51
    en_rise = 4'b0001; en_repeat = 4'b0001;
    mark_edge0();
    apply_stimulus(0, 1'b1);
    for (int k = 1; k <= 75; k++) begin
      logic exp_p;
      exp_p = (k == 11) || (k == 31) || (k == 36) || (k == 41) || (k == 46) || (k == 51);
      @(negedge clock_25);
      check_output("t4_sync0", 32'(sync_button[0]), 32'(exp_p));
      check_output("t4_any",   32'(any_event),      32'(exp_p));
      if (k == 50) apply_stimulus(0, 1'b0);
    end
    check_output("t4_released0", 32'(pressed[0]), 32'd0);

    // Simultaneous press on ch0 and ch3
    en_rise = 4'b1001; en_repeat = 4'b0000;
    mark_edge0();
    apply_stimulus(0, 1'b1);
    apply_stimulus(3, 1'b1);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clock_25);
      check_output("t5_sync0", 32'(sync_button[0]), 32'(k == 11));
      check_output("t5_sync3", 32'(sync_button[3]), 32'(k == 11));
      check_output("t5_any",   32'(any_event),      32'(k == 11));
    end
    apply_stimulus(0, 1'b0);
    apply_stimulus(3, 1'b0);
    idle_cycles(15);

    // Reset in the middle of a press; ch1 held in level mode beforehand
    en_rise = 4'b0001;
    apply_stimulus(1, 1'b1);
    idle_cycles(15);
    check_output("t6_pre_pressed1", 32'(pressed[1]), 32'd1);
    mark_edge0();
    apply_stimulus(0, 1'b1);
    idle_cycles(7);
    #5 reset = 1'b0;
    #1;
    check_output("t6_rst_sync",    32'(sync_button), 32'd0);
    check_output("t6_rst_pressed", 32'(pressed),     32'd0);
    check_output("t6_rst_any",     32'(any_event),   32'd0);
    @(negedge clock_25);
    #5 reset = 1'b1;
    mark_edge0();
    for (int k = 1; k <= 15; k++) begin
      @(negedge clock_25);
      check_output("t6_sync0", 32'(sync_button[0]), 32'(k == 11));
      check_output("t6_sync1", 32'(sync_button[1]), 32'(k >= 11));
    end
    apply_stimulus(0, 1'b0);
    apply_stimulus(1, 1'b0);
    idle_cycles(15);
    check_output("t6_final_pressed", 32'(pressed), 32'd0);

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
